// File: rtl/vga_framebuffer_arbiter.sv
// ---------------------------------------------------------------------------
// vga_framebuffer_arbiter
//
// Shares one single-port framebuffer RAM between a display pixel fetcher and
// a host command port. The display always wins; host commands wait in a small
// FIFO and are issued only in cycles where the display is idle.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_disp_req/i_disp_addr  display fetch strobe and address (one per cycle)
//   o_disp_data/o_disp_valid fetched pixel, valid 2 cycles after the request
//   i_host_valid/o_host_ready host command handshake
//   i_host_we/addr/wdata    host command fields (we=1 write, we=0 read)
//   o_host_rdata/o_host_rvalid host read result, 2 cycles after issue
//   o_mem_addr/we/wdata     RAM port, combinational from the grant decision
//   i_mem_rdata             RAM read data, valid 1 cycle after the address
//   o_range_err             sticky flag: a host command hit addr >= FB_WORDS
//
// Handshake: a host command transfers on a rising edge where i_host_valid and
// o_host_ready are both high. o_host_ready depends only on FIFO occupancy
// (and reset), never on i_host_valid or i_disp_req, so a full FIFO refuses a
// command even in a cycle where it also pops.
// ---------------------------------------------------------------------------
module vga_framebuffer_arbiter #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned FB_WORDS   = 76800,
  parameter int unsigned FIFO_DEPTH = 4     // power of two, at least 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_disp_req,
  input  logic [ADDR_WIDTH-1:0] i_disp_addr,
  output logic [DATA_WIDTH-1:0] o_disp_data,
  output logic                  o_disp_valid,
  input  logic                  i_host_valid,
  output logic                  o_host_ready,
  input  logic                  i_host_we,
  input  logic [ADDR_WIDTH-1:0] i_host_addr,
  input  logic [DATA_WIDTH-1:0] i_host_wdata,
  output logic [DATA_WIDTH-1:0] o_host_rdata,
  output logic                  o_host_rvalid,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_range_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   FB_LIMIT = (ADDR_WIDTH + 1)'(FB_WORDS);

  // What the RAM was used for in a given cycle, carried along with the read
  // latency so the returning data can be steered to the right output.
  typedef enum logic [1:0] {
    TAG_NONE        = 2'd0,
    TAG_DISP        = 2'd1,
    TAG_HOST_RD     = 2'd2,
    TAG_HOST_RD_OOR = 2'd3
  } tag_e;

  // Host command FIFO storage
  logic                  fifo_we_q    [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wdata_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  tag_e tag_s1_q, tag_s1_d;
  tag_e tag_s2_q;

  logic [DATA_WIDTH-1:0] disp_data_q;
  logic [DATA_WIDTH-1:0] host_rdata_q;
  logic                  range_err_q, range_err_d;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  head_we;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic                  head_oor;

  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);

  assign head_we    = fifo_we_q[rd_ptr_q];
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_wdata = fifo_wdata_q[rd_ptr_q];
  assign head_oor   = ({1'b0, head_addr} >= FB_LIMIT);

  assign o_host_ready = !fifo_full && !i_rst;
  assign push         = i_host_valid && o_host_ready;
  // The host only gets the RAM when the display leaves a gap.
  assign pop          = !i_rst && !i_disp_req && !fifo_empty;

  // Grant decision: drives the RAM port directly and picks the tag.
  always_comb begin
    o_mem_addr  = i_disp_addr;
    o_mem_we    = 1'b0;
    o_mem_wdata = head_wdata;
    tag_s1_d    = TAG_NONE;
    if (i_rst) begin
      tag_s1_d = TAG_NONE;
    end else if (i_disp_req) begin
      tag_s1_d = TAG_DISP;
    end else if (pop) begin
      o_mem_addr = head_addr;
      if (head_we) begin
        // Out-of-range writes are dropped silently apart from the flag.
        o_mem_we = !head_oor;
      end else begin
        tag_s1_d = head_oor ? TAG_HOST_RD_OOR : TAG_HOST_RD;
      end
    end
  end

  // FIFO pointer / occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign range_err_d = range_err_q || (pop && head_oor);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tag_s1_q     <= TAG_NONE;
      tag_s2_q     <= TAG_NONE;
      disp_data_q  <= '0;
      host_rdata_q <= '0;
      range_err_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tag_s1_q    <= tag_s1_d;
      tag_s2_q    <= tag_s1_q;
      range_err_q <= range_err_d;
      // i_mem_rdata belongs to the access tagged one cycle ago.
      if (tag_s1_q == TAG_DISP) begin
        disp_data_q <= i_mem_rdata;
      end
      if (tag_s1_q == TAG_HOST_RD) begin
        host_rdata_q <= i_mem_rdata;
      end else if (tag_s1_q == TAG_HOST_RD_OOR) begin
        host_rdata_q <= '0;
      end
    end
  end

  // Payload storage needs no reset; occupancy guards every read.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_we_q[wr_ptr_q]    <= i_host_we;
      fifo_addr_q[wr_ptr_q]  <= i_host_addr;
      fifo_wdata_q[wr_ptr_q] <= i_host_wdata;
    end
  end

  assign o_disp_data   = disp_data_q;
  assign o_host_rdata  = host_rdata_q;
  assign o_disp_valid  = !i_rst && (tag_s2_q == TAG_DISP);
  assign o_host_rvalid = !i_rst && ((tag_s2_q == TAG_HOST_RD) || (tag_s2_q == TAG_HOST_RD_OOR));
  assign o_range_err   = !i_rst && range_err_q;

endmodule

// File: tb/tb_vga_framebuffer_arbiter.sv
`timescale 1ns/1ps
module tb_vga_framebuffer_arbiter;

  localparam int AW       = 17;
  localparam int DW       = 12;
  localparam int FBW      = 76800;
  localparam int DEPTH    = 4;
  localparam int MEM_SIZE = 1 << AW;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_disp_req = 1'b0;
  logic [AW-1:0] i_disp_addr = '0;
  logic [DW-1:0] o_disp_data;
  logic          o_disp_valid;
  logic          i_host_valid = 1'b0;
  logic          o_host_ready;
  logic          i_host_we = 1'b0;
  logic [AW-1:0] i_host_addr = '0;
  logic [DW-1:0] i_host_wdata = '0;
  logic [DW-1:0] o_host_rdata;
  logic          o_host_rvalid;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_we;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata = '0;
  logic          o_range_err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vga_framebuffer_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FB_WORDS(FBW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_disp_req(i_disp_req), .i_disp_addr(i_disp_addr),
    .o_disp_data(o_disp_data), .o_disp_valid(o_disp_valid),
    .i_host_valid(i_host_valid), .o_host_ready(o_host_ready),
    .i_host_we(i_host_we), .i_host_addr(i_host_addr), .i_host_wdata(i_host_wdata),
    .o_host_rdata(o_host_rdata), .o_host_rvalid(o_host_rvalid),
    .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .o_range_err(o_range_err)
  );

  // ---------------- RAM environment: 1-cycle read latency ----------------
  logic [DW-1:0] ram [MEM_SIZE];
  initial begin
    for (int a = 0; a < MEM_SIZE; a++) ram[a] = DW'(a);
    forever begin
      @(posedge clk);
      i_mem_rdata <= ram[o_mem_addr];
      if (o_mem_we) ram[o_mem_addr] = o_mem_wdata;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] ref_mem [MEM_SIZE];
  cmd_t model_q[$];
  exp_t disp_q[$];
  exp_t host_q[$];
  bit   err_m = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs, then at the falling edge compare the
  // combinational outputs against the model and advance the model.
  task automatic step(input bit rst, input bit dreq, input logic [AW-1:0] daddr,
                      input bit hv, input bit hwe, input logic [AW-1:0] haddr,
                      input logic [DW-1:0] hwd, output bit acc);
    cmd_t c;
    exp_t e;
    bit   exp_ready;
    bit   oor;
    i_rst        = rst;
    i_disp_req   = dreq;
    i_disp_addr  = daddr;
    i_host_valid = hv;
    i_host_we    = hwe;
    i_host_addr  = haddr;
    i_host_wdata = hwd;
    @(negedge clk);
    acc = 1'b0;
    if (rst) begin
      check("rst_host_ready", 32'(o_host_ready), 32'(0));
      check("rst_mem_we",     32'(o_mem_we),     32'(0));
      check("rst_range_err",  32'(o_range_err),  32'(0));
      model_q.delete();
      disp_q.delete();
      host_q.delete();
      err_m = 1'b0;
    end else begin
      exp_ready = (model_q.size() < DEPTH);
      check("host_ready", 32'(o_host_ready), 32'(exp_ready));
      check("range_err",  32'(o_range_err),  32'(err_m));
      if (dreq) begin
        check("disp_mem_we",   32'(o_mem_we),   32'(0));
        check("disp_mem_addr", 32'(o_mem_addr), 32'(daddr));
        e.data = ref_mem[daddr];
        e.due  = cyc + 2;
        disp_q.push_back(e);
      end else if (model_q.size() > 0) begin
        c   = model_q.pop_front();
        oor = (int'(c.addr) >= FBW);
        if (c.we && !oor) begin
          check("host_mem_we",    32'(o_mem_we),    32'(1));
          check("host_mem_addr",  32'(o_mem_addr),  32'(c.addr));
          check("host_mem_wdata", 32'(o_mem_wdata), 32'(c.wdata));
          ref_mem[c.addr] = c.wdata;
        end else begin
          check("host_noaccess_we", 32'(o_mem_we), 32'(0));
        end
        if (!c.we) begin
          if (!oor) check("host_rd_addr", 32'(o_mem_addr), 32'(c.addr));
          e.data = oor ? '0 : ref_mem[c.addr];
          e.due  = cyc + 2;
          host_q.push_back(e);
        end
        if (oor) err_m = 1'b1;
      end else begin
        check("idle_mem_we", 32'(o_mem_we), 32'(0));
      end
      if (hv && exp_ready) begin
        acc     = 1'b1;
        c.we    = hwe;
        c.addr  = haddr;
        c.wdata = hwd;
        model_q.push_back(c);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, acc);
  endtask

  // Monitor: compares every output pulse against the head of its queue.
  initial begin
    exp_t e;
    bit   exp_v;
    forever begin
      @(negedge clk);
      #1;
      exp_v = (disp_q.size() > 0) && (disp_q[0].due == cyc);
      check("disp_valid", 32'(o_disp_valid), 32'(exp_v));
      if (exp_v) begin
        e = disp_q.pop_front();
        if (o_disp_valid) check("disp_data", 32'(o_disp_data), 32'(e.data));
      end
      exp_v = (host_q.size() > 0) && (host_q[0].due == cyc);
      check("host_rvalid", 32'(o_host_rvalid), 32'(exp_v));
      if (exp_v) begin
        e = host_q.pop_front();
        if (o_host_rvalid) check("host_rdata", 32'(o_host_rdata), 32'(e.data));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit            acc;
    int            sent;
    logic [DW-1:0] wd [6];
    logic [AW-1:0] ha;
    logic [AW-1:0] da;

    for (int a = 0; a < MEM_SIZE; a++) ref_mem[a] = DW'(a);

    // reset
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, acc);
    idle(1);
    check("reset_disp_data",  32'(o_disp_data),  32'(0));
    check("reset_host_rdata", 32'(o_host_rdata), 32'(0));

    // display-only: addresses 0..3 return their own address
    for (int a = 0; a < 4; a++) step(1'b0, 1'b1, AW'(a), 1'b0, 1'b0, '0, '0, acc);
    idle(3);

    // host write then read of address 5
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, AW'(5), 12'hABC, acc);
    check("wr5_accept", 32'(acc), 32'(1));
    idle(1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, AW'(5), '0, acc);
    idle(4);

    // contention: display holds the RAM for 10 cycles, host pushes 6 writes
    for (int i = 0; i < 6; i++) wd[i] = DW'($urandom_range(0, 4095));
    sent = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, AW'(100 + i), sent < 6, 1'b1, AW'(10 + sent), wd[sent], acc);
      if (acc) sent++;
    end
    check("contention_accepts_during_disp", 32'(sent), 32'(4));
    for (int i = 0; i < 50 && sent < 6; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b1, AW'(10 + sent), wd[sent], acc);
      if (acc) sent++;
    end
    check("contention_total_accepts", 32'(sent), 32'(6));
    idle(6);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b0, AW'(10 + i), '0, acc);
      idle(1);
    end
    idle(4);

    // out-of-range host read
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, AW'(FBW), '0, acc);
    idle(5);
    check("oor_flag_held", 32'(o_range_err), 32'(1));

    // reset mid-operation: 3 reads queued, reset one cycle after first issue
    step(1'b0, 1'b1, AW'(1), 1'b1, 1'b0, AW'(5),  '0, acc);
    step(1'b0, 1'b1, AW'(2), 1'b1, 1'b0, AW'(10), '0, acc);
    step(1'b0, 1'b1, AW'(3), 1'b1, 1'b0, AW'(11), '0, acc);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, acc);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, acc);
    idle(5);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      ha = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(FBW, MEM_SIZE - 1))
                                       : AW'($urandom_range(0, 63));
      da = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, MEM_SIZE - 1))
                                       : AW'($urandom_range(0, 63));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 55, da,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ha,
           DW'($urandom_range(0, 4095)), acc);
    end
    idle(20);
    check("drain_disp_queue", 32'(disp_q.size()), 32'(0));
    check("drain_host_queue", 32'(host_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
